lcd_bus_monitor: RTL and testbench
==================================

// Module: lcd_bus_monitor
// PURPOSE
//  Receiving end of the HD44780-style LCD write bus (rs/rw/e/data) driven by lcd_ctrl.
//  Decodes each write strobe into instructions/characters and mirrors the 2x16 DDRAM image.
//  Exposes a character read port plus busy/protocol-error status.
//  Instantiated beside lcd_ctrl for on-board self-check and as the bench scoreboard.
// PARAMETERS
//  BUSY_CYC   2000   clk cycles busy after any non-clear write (40us @ 50MHz)
//  CLEAR_CYC  76500  clk cycles busy after Clear Display (1.53ms); must be >= 32
// PORTS
//  clk          in   1  system clock, 50MHz
//  rst          in   1  synchronous active-high reset
//  i_lcd_rs     in   1  register select (0 = instruction, 1 = data)
//  i_lcd_rw     in   1  1 = read cycle (ignored)
//  i_lcd_e      in   1  enable strobe; sampled on falling edge
//  i_lcd_data   in   8  bus data
//  i_rd_addr    in   5  mirror read index {row, col[3:0]}
//  o_rd_char    out  8  DDRAM mirror byte at i_rd_addr, combinational
//  o_cur_addr   out  7  current DDRAM address counter
//  o_disp_on    out  1  display-control D bit
//  o_busy       out  1  instruction in progress
//  o_cmd_valid  out  1  1-cycle pulse per accepted write
//  o_cmd_code   out  9  {rs, data} of last accepted write
//  o_err_busy   out  1  sticky: write strobed while o_busy = 1
// BEHAVIOUR
//  - Reset: all 32 cells = 0x20; o_cur_addr = 0; increment mode; o_disp_on = 0; o_busy = 0;
//    o_cmd_valid = 0; o_cmd_code = 0; o_err_busy = 0; FSM = IDLE.
//  - Strobe: e_q registered; transaction when e_q = 1 and i_lcd_e = 0; rs/rw/data sampled
//    that cycle. State/outputs update next cycle (latency 1). rw = 1 is ignored (no pulse).
//  - Instruction decode (rs = 0, highest set bit wins):
//    1xxxxxxx addr = data[6:0] | 01xxxxxx CGRAM set, ignored | 001xxxxx function set, ignored
//    0001SRxx S = 0: cursor move, R = 1 inc / R = 0 dec; S = 1: display shift, ignored
//    00001Dxx o_disp_on = D | 000001Ix I = 1 inc, I = 0 dec | 0000001x addr = 0 | 00000001 clear.
//  - Data write (rs = 1):
//    - If addr is in 0x00-0x0F (row 0) or 0x40-0x4F (row 1), write the byte into that cell;
//      otherwise the byte is discarded.
//    - Then step addr per mode.
//  - Address step: inc 0x27 -> 0x40, 0x67 -> 0x00; dec 0x00 -> 0x67, 0x40 -> 0x27.
//    DDRAM set to a hole (0x28-0x3F, 0x68-0x7F) is held as written; the next inc from a hole
//    wraps per the rule above only at 0x27/0x67, otherwise +1, and 0x7F -> 0x00.
//  - FSM IDLE -> BUSY on any accepted write; load counter with BUSY_CYC.
//  - FSM IDLE -> CLEAR on clear: load counter with CLEAR_CYC, addr = 0, I = 1.
//  - CLEAR writes 0x20 into one cell per cycle, index 0..31; after index 31 it goes to BUSY
//    with the counter continuing.
//  - BUSY -> IDLE when the counter reaches 0. o_busy = (FSM != IDLE).
//  - Simultaneous events: a strobe in the same cycle as the counter expiry counts as busy.
//  - Reset mid-CLEAR or mid-BUSY returns immediately to reset state.
//  - o_cmd_code holds its value between pulses; o_cmd_valid is pulsed for every accepted
//    write, including ignored instructions.
// CONFIGURATION
//  LCD_MON_BUSY_CHECK_EN defined:
//   - Strobes while o_busy = 1 set o_err_busy and are dropped (no pulse, no state change).
//  LCD_MON_BUSY_CHECK_EN undefined:
//   - Busy counter is removed; o_busy = 1 only during the 32-cycle CLEAR sweep.
//   - o_err_busy is tied to 0.
//   - A strobe during the sweep is held in a 1-entry pending register and executed the
//     cycle after the sweep ends.
//   - A second strobe during the same sweep overwrites the pending entry.
// TESTING
//  1. Reset, then read all 32 indices -> every o_rd_char = 0x20, o_cur_addr = 0, o_disp_on = 0.
//  2. Write 0x80, wait; write 'A', 'B' (rs = 1) -> cells 0/1 = 0x41/0x42, o_cur_addr = 0x02,
//     two o_cmd_valid pulses with o_cmd_code = 0x141 then 0x142.
//  3. Write 0xA7 (addr 0x27) then one data byte -> o_cur_addr = 0x40, no mirror cell changed;
//     then write 0xC0 and 'Z' -> index 16 = 0x5A.
//  4. Fill cells, write 0x01 -> o_busy = 1 for CLEAR_CYC cycles, all cells = 0x20 by cycle 32,
//     o_cur_addr = 0.
//  5. (_EN set) Strobe 'Q' 10 cycles after a data write -> o_err_busy = 1, cell unchanged, no
//     pulse; only rst clears it.
//  6. Write 0x04 (dec) at addr 0x40, then a data byte -> o_cur_addr = 0x27; write 0x0C ->
//     o_disp_on = 1; assert rst during BUSY -> all outputs at reset values next cycle.

Source files
------------

// File: rtl/lcd_bus_monitor.sv
// Receive-side monitor for the HD44780 write bus: decodes strobes and mirrors the 2x16 DDRAM.
// Define LCD_MON_BUSY_CHECK_EN to enforce instruction busy times and flag writes that violate them.
module lcd_bus_monitor #(
    parameter int unsigned BUSY_CYC  = 2000,
    parameter int unsigned CLEAR_CYC = 76500
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       i_lcd_rs,
    input  logic       i_lcd_rw,
    input  logic       i_lcd_e,
    input  logic [7:0] i_lcd_data,
    input  logic [4:0] i_rd_addr,
    output logic [7:0] o_rd_char,
    output logic [6:0] o_cur_addr,
    output logic       o_disp_on,
    output logic       o_busy,
    output logic       o_cmd_valid,
    output logic [8:0] o_cmd_code,
    output logic       o_err_busy
);

    typedef enum logic [1:0] {StIdle, StClear, StBusy} state_e;

    if (CLEAR_CYC < 32 || BUSY_CYC == 0) begin : g_param_check
        $error("lcd_bus_monitor: CLEAR_CYC must be >= 32 and BUSY_CYC must be > 0");
    end

    state_e     state_q, state_d;
    logic       e_q;
    logic [7:0] mem_q [32];
    logic [7:0] mem_d [32];
    logic [6:0] addr_q, addr_d;
    logic       inc_q, inc_d;
    logic       disp_q, disp_d;
    logic [4:0] sweep_q, sweep_d;
    logic       valid_q, valid_d;
    logic [8:0] code_q, code_d;

    logic       wr_stb;
    logic       fire;
    logic       fire_rs;
    logic [7:0] fire_data;
    logic       is_clear;

    // DDRAM counter step; the two rows are 0x00-0x27 and 0x40-0x67 and wrap into each other.
    function automatic logic [6:0] addr_step(input logic [6:0] a, input logic up);
        if (up) begin
            if (a == 7'h27)      addr_step = 7'h40;
            else if (a == 7'h67) addr_step = 7'h00;
            else                 addr_step = a + 7'd1;
        end else begin
            if (a == 7'h00)      addr_step = 7'h67;
            else if (a == 7'h40) addr_step = 7'h27;
            else                 addr_step = a - 7'd1;
        end
    endfunction

    assign wr_stb   = e_q & ~i_lcd_e & ~i_lcd_rw;
    assign is_clear = fire & ~fire_rs & (fire_data == 8'h01);

`ifdef LCD_MON_BUSY_CHECK_EN
    localparam int unsigned CntMax = (BUSY_CYC > CLEAR_CYC) ? BUSY_CYC : CLEAR_CYC;
    localparam int unsigned CntW   = $clog2(CntMax + 1);

    logic [CntW-1:0] cnt_q, cnt_d;
    logic            err_q, err_d;

    assign fire      = wr_stb & (state_q == StIdle);
    assign fire_rs   = i_lcd_rs;
    assign fire_data = i_lcd_data;

    always_comb begin
        err_d = err_q | (wr_stb & (state_q != StIdle));
        cnt_d = cnt_q;
        if (is_clear) begin
            cnt_d = CntW'(CLEAR_CYC);
        end else if (fire) begin
            cnt_d = CntW'(BUSY_CYC);
        end else if (cnt_q != '0) begin
            cnt_d = cnt_q - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
            err_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            err_q <= err_d;
        end
    end

    assign o_err_busy = err_q;
`else
    logic       pend_v_q, pend_v_d;
    logic       pend_rs_q, pend_rs_d;
    logic [7:0] pend_data_q, pend_data_d;

    // A held strobe runs first once idle; a strobe arriving in that cycle takes its place.
    assign fire      = (state_q == StIdle) & (pend_v_q | wr_stb);
    assign fire_rs   = pend_v_q ? pend_rs_q : i_lcd_rs;
    assign fire_data = pend_v_q ? pend_data_q : i_lcd_data;

    always_comb begin
        pend_v_d    = pend_v_q;
        pend_rs_d   = pend_rs_q;
        pend_data_d = pend_data_q;
        if (wr_stb && (state_q != StIdle || pend_v_q)) begin
            pend_v_d    = 1'b1;
            pend_rs_d   = i_lcd_rs;
            pend_data_d = i_lcd_data;
        end else if (fire && pend_v_q) begin
            pend_v_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pend_v_q    <= 1'b0;
            pend_rs_q   <= 1'b0;
            pend_data_q <= 8'h00;
        end else begin
            pend_v_q    <= pend_v_d;
            pend_rs_q   <= pend_rs_d;
            pend_data_q <= pend_data_d;
        end
    end

    assign o_err_busy = 1'b0;
`endif

    // FSM: state register
    always_ff @(posedge clk) begin
        if (rst) state_q <= StIdle;
        else     state_q <= state_d;
    end

    // FSM: next state
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: begin
                if (is_clear) state_d = StClear;
`ifdef LCD_MON_BUSY_CHECK_EN
                else if (fire) state_d = StBusy;
`endif
            end
            StClear: begin
                if (sweep_q == 5'd31) begin
`ifdef LCD_MON_BUSY_CHECK_EN
                    state_d = (cnt_q == 1) ? StIdle : StBusy;
`else
                    state_d = StIdle;
`endif
                end
            end
            StBusy: begin
`ifdef LCD_MON_BUSY_CHECK_EN
                if (cnt_q <= 1) state_d = StIdle;
`else
                state_d = StIdle;
`endif
            end
            default: state_d = StIdle;
        endcase
    end

    // FSM: outputs
    always_comb begin
        o_busy = (state_q != StIdle);
    end

    always_comb begin
        mem_d   = mem_q;
        addr_d  = addr_q;
        inc_d   = inc_q;
        disp_d  = disp_q;
        sweep_d = sweep_q;
        valid_d = fire;
        code_d  = code_q;
        if (state_q == StClear) begin
            mem_d[sweep_q] = 8'h20;
            sweep_d        = sweep_q + 5'd1;
        end
        if (fire) begin
            code_d = {fire_rs, fire_data};
            if (fire_rs) begin
                if (addr_q[5:4] == 2'b00) mem_d[{addr_q[6], addr_q[3:0]}] = fire_data;
                addr_d = addr_step(addr_q, inc_q);
            end else if (fire_data[7]) begin
                addr_d = fire_data[6:0];
            end else if (fire_data[6] || fire_data[5]) begin
                addr_d = addr_q;
            end else if (fire_data[4]) begin
                if (!fire_data[3]) addr_d = addr_step(addr_q, fire_data[2]);
            end else if (fire_data[3]) begin
                disp_d = fire_data[2];
            end else if (fire_data[2]) begin
                inc_d = fire_data[1];
            end else if (fire_data[1]) begin
                addr_d = 7'h00;
            end else if (fire_data[0]) begin
                addr_d  = 7'h00;
                inc_d   = 1'b1;
                sweep_d = 5'd0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            e_q     <= 1'b0;
            addr_q  <= 7'h00;
            inc_q   <= 1'b1;
            disp_q  <= 1'b0;
            sweep_q <= 5'd0;
            valid_q <= 1'b0;
            code_q  <= 9'h000;
            for (int i = 0; i < 32; i++) mem_q[i] <= 8'h20;
        end else begin
            e_q     <= i_lcd_e;
            addr_q  <= addr_d;
            inc_q   <= inc_d;
            disp_q  <= disp_d;
            sweep_q <= sweep_d;
            valid_q <= valid_d;
            code_q  <= code_d;
            mem_q   <= mem_d;
        end
    end

    assign o_rd_char   = mem_q[i_rd_addr];
    assign o_cur_addr  = addr_q;
    assign o_disp_on   = disp_q;
    assign o_cmd_valid = valid_q;
    assign o_cmd_code  = code_q;

endmodule

// File: tb/tb_lcd_bus_monitor.sv
// Randomized bench for lcd_bus_monitor against a behavioural DDRAM/command model.
// Build with LCD_MON_BUSY_CHECK_EN defined to exercise the busy-check variant.
module tb_lcd_bus_monitor;

    localparam int unsigned BusyCyc  = 20;
    localparam int unsigned ClearCyc = 40;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       i_lcd_rs = 1'b0;
    logic       i_lcd_rw = 1'b0;
    logic       i_lcd_e = 1'b0;
    logic [7:0] i_lcd_data = 8'h00;
    logic [4:0] i_rd_addr = 5'd0;
    logic [7:0] o_rd_char;
    logic [6:0] o_cur_addr;
    logic       o_disp_on;
    logic       o_busy;
    logic       o_cmd_valid;
    logic [8:0] o_cmd_code;
    logic       o_err_busy;

    lcd_bus_monitor #(
        .BUSY_CYC (BusyCyc),
        .CLEAR_CYC(ClearCyc)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .i_lcd_rs   (i_lcd_rs),
        .i_lcd_rw   (i_lcd_rw),
        .i_lcd_e    (i_lcd_e),
        .i_lcd_data (i_lcd_data),
        .i_rd_addr  (i_rd_addr),
        .o_rd_char  (o_rd_char),
        .o_cur_addr (o_cur_addr),
        .o_disp_on  (o_disp_on),
        .o_busy     (o_busy),
        .o_cmd_valid(o_cmd_valid),
        .o_cmd_code (o_cmd_code),
        .o_err_busy (o_err_busy)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model of the visible LCD state
    logic [7:0] m_mem [32];
    int         m_addr;
    logic       m_inc;
    logic       m_disp;
    logic [8:0] m_code;
    logic       m_err;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic int next_addr(input int a, input logic up);
        if (up) return (a == 'h27) ? 'h40 : (a == 'h67) ? 0 : (a + 1) % 128;
        else    return (a == 0) ? 'h67 : (a == 'h40) ? 'h27 : a - 1;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 32; i++) m_mem[i] = 8'h20;
        m_addr = 0;
        m_inc  = 1'b1;
        m_disp = 1'b0;
        m_code = 9'h000;
        m_err  = 1'b0;
    endtask

    task automatic model_apply(input logic rs, input logic [7:0] d);
        m_code = {rs, d};
        if (rs) begin
            if (m_addr < 16) m_mem[m_addr] = d;
            else if (m_addr >= 'h40 && m_addr < 'h50) m_mem[m_addr - 'h40 + 16] = d;
            m_addr = next_addr(m_addr, m_inc);
        end else if (d >= 8'h80) begin
            m_addr = int'(d) - 'h80;
        end else if (d >= 8'h20) begin
            m_addr = m_addr;
        end else if (d >= 8'h10) begin
            if (d[3] == 1'b0) m_addr = next_addr(m_addr, d[2]);
        end else if (d >= 8'h08) begin
            m_disp = d[2];
        end else if (d >= 8'h04) begin
            m_inc = d[1];
        end else if (d >= 8'h02) begin
            m_addr = 0;
        end else if (d == 8'h01) begin
            for (int i = 0; i < 32; i++) m_mem[i] = 8'h20;
            m_addr = 0;
            m_inc  = 1'b1;
        end
    endtask

    function automatic int busy_len(input logic rs, input logic rw, input logic [7:0] d);
        if (rw) return 0;
`ifdef LCD_MON_BUSY_CHECK_EN
        return (!rs && d == 8'h01) ? ClearCyc : BusyCyc;
`else
        return (!rs && d == 8'h01) ? 32 : 0;
`endif
    endfunction

    task automatic strobe(input logic rs, input logic rw, input logic [7:0] d);
        i_lcd_rs   = rs;
        i_lcd_rw   = rw;
        i_lcd_data = d;
        i_lcd_e    = 1'b1;
        step();
        i_lcd_e = 1'b0;
        step();
    endtask

    task automatic check_state(input string tag);
        check_eq({tag, ".cur_addr"}, o_cur_addr, m_addr);
        check_eq({tag, ".disp_on"}, o_disp_on, m_disp);
        check_eq({tag, ".err_busy"}, o_err_busy, m_err);
    endtask

    task automatic check_mem(input string tag);
        for (int i = 0; i < 32; i++) begin
            i_rd_addr = 5'(i);
            #1;
            check_eq($sformatf("%s.cell%0d", tag, i), o_rd_char, m_mem[i]);
        end
        step();
    endtask

    task automatic wait_idle(output int n);
        n = 0;
        while (o_busy && n < ClearCyc + 64) begin
            n++;
            step();
        end
    endtask

    // One bus write followed by pulse, hold and busy-length checks
    task automatic do_op(input string tag, input logic rs, input logic rw, input logic [7:0] d);
        int n;
        int exp_busy;
        exp_busy = busy_len(rs, rw, d);
        strobe(rs, rw, d);
        if (!rw) model_apply(rs, d);
        check_eq({tag, ".valid"}, o_cmd_valid, !rw);
        check_eq({tag, ".code"}, o_cmd_code, m_code);
        check_state(tag);
        n = o_busy ? 1 : 0;
        step();
        check_eq({tag, ".valid_drop"}, o_cmd_valid, 1'b0);
        check_eq({tag, ".code_hold"}, o_cmd_code, m_code);
        while (o_busy && n < ClearCyc + 64) begin
            n++;
            step();
        end
        check_eq({tag, ".busy_len"}, n, exp_busy);
    endtask

    task automatic apply_reset(input string tag);
        rst     = 1'b1;
        i_lcd_e = 1'b0;
        step();
        rst = 1'b0;
        model_reset();
        check_state(tag);
        check_eq({tag, ".busy"}, o_busy, 1'b0);
        check_eq({tag, ".valid"}, o_cmd_valid, 1'b0);
        check_eq({tag, ".code"}, o_cmd_code, 9'h000);
        check_mem(tag);
    endtask

    initial begin
        int n;
        int pulses;
        int k;
        logic [7:0] d;

        model_reset();
        step();
        apply_reset("reset");

        do_op("setaddr0", 1'b0, 1'b0, 8'h80);
        do_op("wrA", 1'b1, 1'b0, 8'h41);
        do_op("wrB", 1'b1, 1'b0, 8'h42);
        do_op("set27", 1'b0, 1'b0, 8'hA7);
        do_op("wr27", 1'b1, 1'b0, 8'h33);
        do_op("set40", 1'b0, 1'b0, 8'hC0);
        do_op("wrZ", 1'b1, 1'b0, 8'h5A);
        check_mem("rows");
        do_op("set40b", 1'b0, 1'b0, 8'hC0);
        do_op("dec", 1'b0, 1'b0, 8'h04);
        do_op("wrdec", 1'b1, 1'b0, 8'h44);
        do_op("dispon", 1'b0, 1'b0, 8'h0C);
        do_op("inc", 1'b0, 1'b0, 8'h06);
        do_op("clear", 1'b0, 1'b0, 8'h01);
        check_mem("clear");

`ifdef LCD_MON_BUSY_CHECK_EN
        // Write inside the busy window is flagged and dropped
        strobe(1'b1, 1'b0, 8'h50);
        model_apply(1'b1, 8'h50);
        repeat (8) step();
        strobe(1'b1, 1'b0, 8'h51);
        m_err = 1'b1;
        check_eq("errbusy.valid", o_cmd_valid, 1'b0);
        check_state("errbusy");
        wait_idle(n);
        check_eq("errbusy.code", o_cmd_code, m_code);
        check_state("errbusy.idle");
        check_mem("errbusy");
        apply_reset("errreset");
`else
        // Writes during the sweep: last one is kept and runs once the sweep ends
        strobe(1'b0, 1'b0, 8'h01);
        model_apply(1'b0, 8'h01);
        check_eq("pend.busy", o_busy, 1'b1);
        repeat (5) step();
        strobe(1'b1, 1'b0, 8'h51);
        repeat (3) step();
        strobe(1'b1, 1'b0, 8'h52);
        pulses = 0;
        n = 0;
        while (o_busy && n < 100) begin
            n++;
            if (o_cmd_valid) pulses++;
            step();
        end
        repeat (3) begin
            if (o_cmd_valid) pulses++;
            step();
        end
        model_apply(1'b1, 8'h52);
        check_eq("pend.pulses", pulses, 1);
        check_eq("pend.code", o_cmd_code, m_code);
        check_state("pend");
        check_mem("pend");
`endif

        for (int it = 0; it < 120; it++) begin
            k = $urandom_range(0, 15);
            d = 8'($urandom);
            case (k)
                0, 1, 2, 3, 4, 5: do_op("rnd.data", 1'b1, 1'b0, 8'($urandom_range(32, 126)));
                6:  do_op("rnd.ddram", 1'b0, 1'b0, {1'b1, d[6:0]});
                7:  do_op("rnd.entry", 1'b0, 1'b0, {6'b000001, d[1:0]});
                8:  do_op("rnd.shift", 1'b0, 1'b0, {4'b0001, d[3:0]});
                9:  do_op("rnd.dispctl", 1'b0, 1'b0, {5'b00001, d[2:0]});
                10: do_op("rnd.home", 1'b0, 1'b0, {7'b0000001, d[0]});
                11: do_op("rnd.cgram", 1'b0, 1'b0, {2'b01, d[5:0]});
                12: do_op("rnd.funcset", 1'b0, 1'b0, {3'b001, d[4:0]});
                13: do_op("rnd.read", d[7], 1'b1, d);
                14: begin
                    if (d[1:0] == 2'b00) do_op("rnd.clear", 1'b0, 1'b0, 8'h01);
                    else                 do_op("rnd.data2", 1'b1, 1'b0, d);
                end
                default: do_op("rnd.byte", 1'b1, 1'b0, d);
            endcase
            i_rd_addr = 5'($urandom_range(0, 31));
            #1;
            check_eq("rnd.cell", o_rd_char, m_mem[i_rd_addr]);
            step();
            if (it % 30 == 29) check_mem("rnd.mem");
        end
        check_mem("rnd.final");

        // Reset while busy returns everything to the reset image
        strobe(1'b0, 1'b0, 8'h01);
        repeat (4) step();
        apply_reset("rst_clear");
        do_op("wrC", 1'b1, 1'b0, 8'h43);
        do_op("dispon2", 1'b0, 1'b0, 8'h0F);
        strobe(1'b1, 1'b0, 8'h44);
        step();
        apply_reset("rst_busy");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: simulation did not finish, expected completion");
        $fatal(1, "timeout");
    end

endmodule
